pixel_mem_arbiter: RTL and testbench

Parametrised single-port pixel memory shared by NUM_CH requesters through a request/grant arbiter. It replaces the static two-user select scheme: the requester is chosen dynamically by round-robin or fixed priority, and a lock input holds the grant for burst transfers. It sits between the pixel producer/consumer blocks and the image storage array, giving each channel a registered read-data path with a per-channel valid strobe.

---
 rtl/pixel_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_pixel_mem_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pixel_mem_arbiter.sv
// Single-port pixel memory shared by NUM_CH requesters through a round-robin /
// fixed-priority arbiter with per-channel grant lock and a registered read path.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_OPEN   | no grant hold; every cycle is arbitrated normally
// ST_LOCKED | locked_ch keeps the grant for as long as it keeps requesting
module pixel_mem_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int NUM_CH = 2
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     rr_mode,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        wren,
  input  logic [NUM_CH-1:0]        lock,
  input  logic [NUM_CH*ADDR_W-1:0] addr,
  input  logic [NUM_CH*DATA_W-1:0] wdata,
  output logic [NUM_CH-1:0]        gnt,
  output logic [NUM_CH-1:0]        rvalid,
  output logic [DATA_W-1:0]        rdata
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

  lock_state_t       state, state_nxt;
  logic [CH_W-1:0]   locked_ch, locked_ch_nxt;
  logic [CH_W-1:0]   last_gnt;
  logic [CH_W-1:0]   gnt_idx;
  logic [CH_W-1:0]   cand;
  logic              gnt_any;
  logic              found;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_wren;
  logic              do_wr;
  logic              do_rd;

  logic [DATA_W-1:0] mem [DEPTH];

  // Grant is forced off while reset is asserted so nothing can touch memory.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    found   = 1'b0;
    cand    = '0;
    if (!n_rst) begin
      gnt_any = 1'b0;
    end else if (state == ST_LOCKED && req[locked_ch]) begin
      gnt_idx = locked_ch;
      gnt_any = 1'b1;
    end else if (rr_mode) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        cand = CH_W'((int'(last_gnt) + k) % NUM_CH);
        if (!found && req[cand]) begin
          found   = 1'b1;
          gnt_idx = cand;
        end
      end
      gnt_any = found;
    end else begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (req[i]) begin
          gnt_idx = CH_W'(i);
          gnt_any = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wren  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_idx == CH_W'(i)) begin
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
        sel_wren  = wren[i];
      end
    end
  end

  assign do_wr = gnt_any & sel_wren;
  assign do_rd = gnt_any & ~sel_wren;

  // A new lock taken by the winner overrides release of a stale one.
  always_comb begin
    state_nxt     = state;
    locked_ch_nxt = locked_ch;
    if (state == ST_LOCKED && !req[locked_ch]) state_nxt = ST_OPEN;
    if (gnt_any) begin
      if (lock[gnt_idx]) begin
        state_nxt     = ST_LOCKED;
        locked_ch_nxt = gnt_idx;
      end else if (state == ST_LOCKED && gnt_idx == locked_ch) begin
        state_nxt = ST_OPEN;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= ST_OPEN;
      locked_ch <= '0;
      last_gnt  <= CH_W'(NUM_CH - 1);
      rvalid    <= '0;
      rdata     <= '0;
    end else begin
      state     <= state_nxt;
      locked_ch <= locked_ch_nxt;
      if (gnt_any) last_gnt <= gnt_idx;
      rvalid <= do_rd ? gnt : '0;
      if (do_rd) rdata <= mem[sel_addr];
    end
  end

  // Storage is deliberately unreset so image contents survive n_rst.
  always_ff @(posedge clk) begin
    if (do_wr) mem[sel_addr] <= sel_wdata;
  end

endmodule

// File: tb/tb_pixel_mem_arbiter.sv
// Directed bench for pixel_mem_arbiter (NUM_CH=2, DATA_W=8, ADDR_W=10) with
// hand-computed grant, read-valid and read-data expectations.
module tb_pixel_mem_arbiter;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        rr_mode;
  logic [1:0]  req;
  logic [1:0]  wren;
  logic [1:0]  lock;
  logic [19:0] addr;
  logic [15:0] wdata;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [7:0]  rdata;

  int n_cmp = 0;
  int n_err = 0;

  pixel_mem_arbiter #(.DATA_W(8), .ADDR_W(10), .NUM_CH(2)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .rr_mode (rr_mode),
    .req     (req),
    .wren    (wren),
    .lock    (lock),
    .addr    (addr),
    .wdata   (wdata),
    .gnt     (gnt),
    .rvalid  (rvalid),
    .rdata   (rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ch(input int ch, input logic rq, input logic we, input logic lk,
                        input logic [9:0] a, input logic [7:0] d);
    req[ch]           = rq;
    wren[ch]          = we;
    lock[ch]          = lk;
    addr[ch*10 +: 10] = a;
    wdata[ch*8 +: 8]  = d;
  endtask

  logic [1:0] rr_gnt [4];
  logic [7:0] rr_dat [4];

  initial begin
    rr_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
    rr_dat = '{8'hAA, 8'hF0, 8'hAA, 8'hF0};
    n_rst = 1'b0; rr_mode = 1'b1;
    req = 2'b11; wren = 2'b00; lock = 2'b00; addr = '0; wdata = '0;
    repeat (3) step();
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    @(negedge clk);
    n_rst = 1'b1; req = 2'b00;
    step();

    // ch0 write AA@5 then read it back
    set_ch(0, 1, 1, 0, 10'd5, 8'hAA);
    #1 chk("wr_gnt", 32'(gnt), 32'h1);
    step();
    chk("wr_no_rvalid", 32'(rvalid), 32'h0);
    set_ch(0, 1, 0, 0, 10'd5, 8'h00);
    #1 chk("rd_gnt", 32'(gnt), 32'h1);
    step();
    #1;
    chk("rd_rvalid", 32'(rvalid), 32'h1);
    chk("rd_rdata", 32'(rdata), 32'hAA);
    set_ch(0, 0, 0, 0, 10'd0, 8'h00);
    set_ch(1, 1, 1, 0, 10'd6, 8'hF0);
    #1 chk("wr1_gnt", 32'(gnt), 32'h2);
    step();
    #1 chk("hold_rdata", 32'(rdata), 32'hAA);

    // round robin, both reading; last winner was ch1 so ch0 goes first
    rr_mode = 1'b1;
    set_ch(0, 1, 0, 0, 10'd5, 8'h00);
    set_ch(1, 1, 0, 0, 10'd6, 8'h00);
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(rr_gnt[i]));
      step();
      #1;
      chk($sformatf("rr_rvalid%0d", i), 32'(rvalid), 32'(rr_gnt[i]));
      chk($sformatf("rr_rdata%0d", i), 32'(rdata), 32'(rr_dat[i]));
    end

    // fixed priority starves ch1 until ch0 drops
    rr_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("fp_gnt%0d", i), 32'(gnt), 32'h1);
      step();
    end
    req[0] = 1'b0;
    #1 chk("fp_drop_gnt", 32'(gnt), 32'h2);
    step();
    #1 chk("fp_drop_rdata", 32'(rdata), 32'hF0);

    // lock: ch1 takes the grant alone, then holds it against ch0 in rr mode
    rr_mode = 1'b1;
    set_ch(1, 1, 0, 1, 10'd6, 8'h00);
    #1 chk("lk_gnt0", 32'(gnt), 32'h2);
    step();
    req[0] = 1'b1;
    #1 chk("lk_gnt1", 32'(gnt), 32'h2);
    step();
    #1 chk("lk_gnt2", 32'(gnt), 32'h2);
    step();
    lock[1] = 1'b0;
    #1 chk("lk_gnt3", 32'(gnt), 32'h2);
    step();
    #1;
    chk("lk_rvalid3", 32'(rvalid), 32'h2);
    chk("unlk_gnt", 32'(gnt), 32'h1);
    step();
    req = 2'b00;
    step();

    // winner writes while other channel waits to read same address
    rr_mode = 1'b0;
    set_ch(0, 1, 1, 0, 10'd8, 8'h99);
    set_ch(1, 1, 0, 0, 10'd8, 8'h00);
    #1 chk("wrrd_gnt0", 32'(gnt), 32'h1);
    step();
    req[0] = 1'b0;
    #1 chk("wrrd_gnt1", 32'(gnt), 32'h2);
    step();
    #1;
    chk("wrrd_rvalid", 32'(rvalid), 32'h2);
    chk("wrrd_rdata", 32'(rdata), 32'h99);
    req = 2'b00;

    // read the cycle after a write returns new data
    set_ch(0, 1, 1, 0, 10'd7, 8'h33);
    step();
    wren[0] = 1'b0;
    step();
    #1 chk("raw_rdata", 32'(rdata), 32'h33);

    // persistence through reset, with reset dropped mid-read
    set_ch(0, 1, 1, 0, 10'd1023, 8'h55);
    step();
    wren[0] = 1'b0;
    step();
    #1 chk("pre_rst_rvalid", 32'(rvalid), 32'h1);
    n_rst = 1'b0;
    #1;
    chk("async_rvalid", 32'(rvalid), 32'h0);
    chk("async_rdata", 32'(rdata), 32'h0);
    chk("async_gnt", 32'(gnt), 32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    step();
    #1;
    chk("post_rst_rvalid", 32'(rvalid), 32'h1);
    chk("post_rst_rdata", 32'(rdata), 32'h55);
    req = 2'b00;
    step();
    #1 chk("idle_rvalid", 32'(rvalid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
